// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpMul  = 4'd2,
    OpOr   = 4'd3,
    OpMod  = 4'd4,
    OpAnd  = 4'd5,
    OpPass = 4'd6,
    OpShl  = 4'd7,
    OpDiv  = 4'd8,
    OpShr  = 4'd9
  } alu_op_e;

  // Bit positions inside the {N,Z,C,V} flag nibble.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [1:0] alu_state_e;
  localparam alu_state_e StIdle = 2'd0;
  localparam alu_state_e StDiv  = 2'd1;
  localparam alu_state_e StHold = 2'd2;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OpDiv) || (op == OpMod);
  endfunction

endpackage

// File: rtl/div_restoring.sv
// Unsigned restoring divider: one quotient bit per clock, N steps per division.
// quotient/remainder show the post-step values of the step in progress, so they
// are final in the cycle where done is high.
module div_restoring #(
  parameter int unsigned N     = 8,
  parameter int unsigned LOG_N = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     rem_q, rem_d;
  logic [N-1:0]     dvs_q;
  logic [LOG_N-1:0] cnt_q;
  logic             busy_q;

  logic [N:0]   rem_shift;
  logic [N-1:0] rem_sub;
  logic         fits;

  always_comb begin
    rem_shift = {rem_q, quo_q[N-1]};
    fits      = rem_shift >= {1'b0, dvs_q};
    // When the divisor fits, the true difference is below 2^N, so N-bit wraparound is exact.
    rem_sub   = rem_shift[N-1:0] - dvs_q;
    if (fits) begin
      rem_d = rem_sub;
      quo_d = {quo_q[N-2:0], 1'b1};
    end else begin
      rem_d = rem_shift[N-1:0];
      quo_d = {quo_q[N-2:0], 1'b0};
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == LOG_N'(N - 1));
  assign quotient  = quo_d;
  assign remainder = rem_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides: single-cycle ops finish on the
// accept edge, DIV/MOD with a nonzero divisor run through the iterative divider.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned LOG_N = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctrl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         div_zero
);

  localparam logic [N-1:0] NVal = N'(N);

  alu_state_e   state_q, state_d;
  logic [N-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic         div_zero_q, div_zero_d;
  logic         out_valid_q, out_valid_d;
  logic         is_mod_q, is_mod_d;

  logic         accept;
  logic         div_start;
  logic         div_busy;
  logic         div_done;
  logic [N-1:0] div_quo;
  logic [N-1:0] div_rem;
  logic [N-1:0] div_res;

  logic [N:0]     sum_ext;
  logic [N:0]     diff_ext;
  logic [2*N-1:0] prod;
  logic           shift_oob;
  logic [N-1:0]   alu_res;
  logic           alu_c;
  logic           alu_v;

  assign in_ready = (state_q == StIdle) && !div_busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  div_restoring #(
    .N     (N),
    .LOG_N (LOG_N)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign div_res = is_mod_q ? div_rem : div_quo;

  // Single-cycle datapath; DIV/MOD entries only cover the divide-by-zero case.
  always_comb begin
    sum_ext   = {1'b0, a} + {1'b0, b};
    diff_ext  = {1'b0, a} - {1'b0, b};
    prod      = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    shift_oob = (b >= NVal);
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (ctrl)
      OpAdd: begin
        alu_res = sum_ext[N-1:0];
        alu_c   = sum_ext[N];
        alu_v   = (a[N-1] == b[N-1]) && (alu_res[N-1] != a[N-1]);
      end
      OpSub: begin
        alu_res = diff_ext[N-1:0];
        alu_c   = ~diff_ext[N];
        alu_v   = (a[N-1] != b[N-1]) && (alu_res[N-1] != a[N-1]);
      end
      OpMul: begin
        alu_res = prod[N-1:0];
        alu_c   = |prod[2*N-1:N];
        alu_v   = alu_c;
      end
      OpOr:    alu_res = a | b;
      OpAnd:   alu_res = a & b;
      OpPass:  alu_res = b;
      OpShl:   alu_res = shift_oob ? '0 : (a << b[LOG_N-1:0]);
      OpShr:   alu_res = shift_oob ? '0 : (a >> b[LOG_N-1:0]);
      OpDiv:   alu_res = '1;
      OpMod:   alu_res = a;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;
    is_mod_d    = is_mod_q;
    div_start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (is_div_op(ctrl) && (b != '0)) begin
            div_start = 1'b1;
            is_mod_d  = (ctrl == OpMod);
            state_d   = StDiv;
          end else begin
            result_d            = alu_res;
            flags_d[FLAG_N]     = alu_res[N-1];
            flags_d[FLAG_Z]     = (alu_res == '0);
            flags_d[FLAG_C]     = alu_c;
            flags_d[FLAG_V]     = alu_v;
            div_zero_d          = is_div_op(ctrl);
            out_valid_d         = 1'b1;
          end
        end
      end
      StDiv: begin
        if (div_done) begin
          result_d        = div_res;
          flags_d[FLAG_N] = div_res[N-1];
          flags_d[FLAG_Z] = (div_res == '0);
          flags_d[FLAG_C] = 1'b0;
          flags_d[FLAG_V] = 1'b0;
          div_zero_d      = 1'b0;
          out_valid_d     = 1'b1;
          state_d         = out_ready ? StIdle : StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      result_q    <= '0;
      flags_q     <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      is_mod_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
      is_mod_q    <= is_mod_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign div_zero  = div_zero_q;

endmodule
